stopwatch_controller: RTL

STOPWATCH_CONTROLLER -- requirements
Module: stopwatch_controller

---
 rtl/stopwatch_controller.sv | 101 ++++++++++
 1 files changed

// File: rtl/stopwatch_controller.sv
// Stopwatch control FSM: turns start/stop and lap/reset button edges into time-counter
// control, a lap-freezable display copy of the live time, and a saturating lap count.
module stopwatch_controller #(
  parameter int MAX_MINUTES = 59
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start_stop,
  input  logic       lap_reset,
  input  logic [5:0] minutes,
  input  logic [5:0] seconds,
  output logic       counter_reset,
  output logic       hold_clock,
  output logic [5:0] display_minutes,
  output logic [5:0] display_seconds,
  output logic [3:0] lap_count,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RUNNING = 3'd1,
    PAUSED  = 3'd2,
    LAP     = 3'd3,
    DONE    = 3'd4
  } state_t;

  state_t cur_state;
  state_t nxt_state;
  logic   ss_prev;
  logic   lr_prev;
  logic   ss_edge;
  logic   lr_edge;
  logic   at_limit;

  // A simultaneous lap_reset edge is discarded in favour of start_stop.
  assign ss_edge  = start_stop & ~ss_prev;
  assign lr_edge  = lap_reset & ~lr_prev & ~ss_edge;
  assign at_limit = (minutes == 6'(MAX_MINUTES)) && (seconds == 6'd59);

  always_comb begin
    nxt_state = cur_state;
    case (cur_state)
      IDLE: begin
        if (ss_edge) nxt_state = RUNNING;
      end
      RUNNING: begin
        if (at_limit)     nxt_state = DONE;
        else if (ss_edge) nxt_state = PAUSED;
        else if (lr_edge) nxt_state = LAP;
      end
      PAUSED: begin
        if (ss_edge)      nxt_state = RUNNING;
        else if (lr_edge) nxt_state = IDLE;
      end
      LAP: begin
        if (at_limit)     nxt_state = DONE;
        else if (ss_edge) nxt_state = PAUSED;
        else if (lr_edge) nxt_state = RUNNING;
      end
      DONE: begin
        if (lr_edge) nxt_state = IDLE;
      end
      default: nxt_state = IDLE;
    endcase
  end

  // Edge-detect history follows the buttons even during reset, so a button
  // held across reset release is not seen as a new press.
  always_ff @(posedge clock) begin
    ss_prev <= start_stop;
    lr_prev <= lap_reset;
    if (reset) begin
      cur_state       <= IDLE;
      counter_reset   <= 1'b1;
      hold_clock      <= 1'b1;
      display_minutes <= 6'd0;
      display_seconds <= 6'd0;
      lap_count       <= 4'd0;
    end else begin
      cur_state     <= nxt_state;
      counter_reset <= (nxt_state == IDLE);
      hold_clock    <= (nxt_state != RUNNING) && (nxt_state != LAP);
      if (nxt_state == IDLE && cur_state != IDLE) begin
        display_minutes <= 6'd0;
        display_seconds <= 6'd0;
      end else if (!(cur_state == LAP && nxt_state == LAP)) begin
        display_minutes <= minutes;
        display_seconds <= seconds;
      end
      if (nxt_state == IDLE) begin
        lap_count <= 4'd0;
      end else if (cur_state == RUNNING && nxt_state == LAP && lap_count != 4'd15) begin
        lap_count <= lap_count + 4'd1;
      end
    end
  end

  assign state = cur_state;

endmodule
